// File: rtl/aegnn_pkg.sv
// Shared types for the aegnn FC-head datapath: grid index, feature width
// and the scheduler state encoding.
package aegnn;

  localparam int unsigned GRID_W  = 10;
  localparam int unsigned F_WIDTH = 8;

  typedef logic [GRID_W-1:0] grid_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_CLEAN_DRAIN,
    ST_CLEAN_PULSE,
    ST_CLEAN_ACK
  } fc_sched_state_e;

endpackage

// File: rtl/fc_req_queue.sv
// Coalescing circular FIFO of {grid_idx, feat_pack}; a push whose grid_idx
// matches a queued entry overwrites that entry's features in place.
module fc_req_queue
  import aegnn::*;
#(
  parameter int unsigned L4_OUT_C    = 32,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  grid_idx_t                         push_grid,
  input  logic [L4_OUT_C-1:0][F_WIDTH-1:0]  push_feat,
  output logic                              match,
  input  logic                              pop,
  input  logic                              flush,
  output grid_idx_t                         head_grid,
  output logic [L4_OUT_C-1:0][F_WIDTH-1:0]  head_feat,
  output logic                              empty,
  output logic                              full
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W+1)'(QUEUE_DEPTH);

  grid_idx_t                        grid_q [QUEUE_DEPTH];
  logic [L4_OUT_C-1:0][F_WIDTH-1:0] feat_q [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]           vld_q;
  logic [PTR_W-1:0]                 rd_ptr;
  logic [PTR_W-1:0]                 wr_ptr;
  logic [PTR_W:0]                   count;
  logic [PTR_W-1:0]                 match_idx;
  logic                             do_push;
  logic                             do_pop;

  // Entries are unique by grid_idx, so at most one slot can hit.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
      if (vld_q[i] && (grid_q[i] == push_grid)) begin
        match     = 1'b1;
        match_idx = PTR_W'(i);
      end
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == CNT_DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && !match && !full;

  assign head_grid = grid_q[rd_ptr];
  // Coalescing onto the head in its pop cycle must issue the new features.
  assign head_feat = (push && match && (match_idx == rd_ptr)) ? push_feat : feat_q[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        grid_q[i] <= '0;
        feat_q[i] <= '0;
      end
      vld_q  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      vld_q  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_ONE;
      end
      if (push && match) begin
        feat_q[match_idx] <= push_feat;
      end else if (do_push) begin
        grid_q[wr_ptr] <= push_grid;
        feat_q[wr_ptr] <= push_feat;
        vld_q[wr_ptr]  <= 1'b1;
        wr_ptr         <= wr_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fc_scheduler.sv
// Issues queued pooled-feature requests to the linear FC unit one at a time
// and sequences event-stream cleans behind in-flight work.
module fc_scheduler
  import aegnn::*;
#(
  parameter int unsigned L4_OUT_C    = 32,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  grid_idx_t                         req_grid_idx,
  input  logic [L4_OUT_C-1:0][F_WIDTH-1:0]  req_feat_pack,
  input  logic                              clean_req,
  output logic                              clean_done,
  output logic                              lin_start,
  output grid_idx_t                         lin_grid_idx,
  output logic [L4_OUT_C-1:0][F_WIDTH-1:0]  lin_feat_pack,
  output logic                              lin_clean,
  input  logic                              lin_done,
  output logic                              busy,
  output logic [CNT_W-1:0]                  issue_cnt,
  output logic [CNT_W-1:0]                  coalesce_cnt
);

  fc_sched_state_e                  state;
  fc_sched_state_e                  state_d;
  logic                             clean_pending;
  logic                             clean_eff;
  logic                             accept;
  logic                             push;
  logic                             pop;
  logic                             q_match;
  logic                             q_empty;
  logic                             q_full;
  grid_idx_t                        head_grid;
  logic [L4_OUT_C-1:0][F_WIDTH-1:0] head_feat;
  logic                             lin_start_d;
  logic                             lin_clean_d;
  logic                             clean_done_d;

  assign req_ready = !q_full && !clean_pending;
  assign accept    = req_valid && req_ready;
  assign clean_eff = clean_req && !clean_pending;
  // A request handshaken alongside a clean is dropped rather than queued.
  assign push      = accept && !clean_eff;
  assign busy      = !q_empty || (state != ST_IDLE);

  fc_req_queue #(
    .L4_OUT_C    (L4_OUT_C),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_grid (req_grid_idx),
    .push_feat (req_feat_pack),
    .match     (q_match),
    .pop       (pop),
    .flush     (clean_eff),
    .head_grid (head_grid),
    .head_feat (head_feat),
    .empty     (q_empty),
    .full      (q_full)
  );

  always_comb begin
    state_d      = state;
    pop          = 1'b0;
    lin_start_d  = 1'b0;
    lin_clean_d  = 1'b0;
    clean_done_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clean_eff) begin
          state_d     = ST_CLEAN_PULSE;
          lin_clean_d = 1'b1;
        end else if (!q_empty) begin
          pop         = 1'b1;
          lin_start_d = 1'b1;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (lin_done) begin
          if (clean_eff) begin
            state_d     = ST_CLEAN_PULSE;
            lin_clean_d = 1'b1;
          end else if (!q_empty) begin
            pop         = 1'b1;
            lin_start_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (clean_eff) begin
          state_d = ST_CLEAN_DRAIN;
        end
      end
      ST_CLEAN_DRAIN: begin
        if (lin_done) begin
          state_d     = ST_CLEAN_PULSE;
          lin_clean_d = 1'b1;
        end
      end
      ST_CLEAN_PULSE: begin
        state_d      = ST_CLEAN_ACK;
        clean_done_d = 1'b1;
      end
      ST_CLEAN_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      clean_pending <= 1'b0;
      lin_start     <= 1'b0;
      lin_clean     <= 1'b0;
      clean_done    <= 1'b0;
      lin_grid_idx  <= '0;
      lin_feat_pack <= '0;
      issue_cnt     <= '0;
      coalesce_cnt  <= '0;
    end else begin
      state      <= state_d;
      lin_start  <= lin_start_d;
      lin_clean  <= lin_clean_d;
      clean_done <= clean_done_d;
      if (state == ST_CLEAN_ACK) begin
        clean_pending <= 1'b0;
      end else if (clean_eff) begin
        clean_pending <= 1'b1;
      end
      if (lin_start_d) begin
        lin_grid_idx  <= head_grid;
        lin_feat_pack <= head_feat;
      end
      if (lin_start_d && (issue_cnt != '1)) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
      if (push && q_match && (coalesce_cnt != '1)) begin
        coalesce_cnt <= coalesce_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fc_scheduler.sv
// Directed bench for fc_scheduler; the FC unit is modelled by driving lin_done by hand.
module tb_fc_scheduler;
  import aegnn::*;

  localparam int unsigned L4_OUT_C = 32;
  localparam int unsigned CNT_W    = 16;

  typedef logic [L4_OUT_C-1:0][F_WIDTH-1:0] feat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  grid_idx_t         req_grid_idx = '0;
  feat_t             req_feat_pack = '0;
  logic              clean_req = 1'b0;
  logic              clean_done;
  logic              lin_start;
  grid_idx_t         lin_grid_idx;
  feat_t             lin_feat_pack;
  logic              lin_clean;
  logic              lin_done = 1'b0;
  logic              busy;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  coalesce_cnt;

  int checks = 0;
  int errors = 0;

  fc_scheduler #(
    .L4_OUT_C    (L4_OUT_C),
    .QUEUE_DEPTH (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_grid_idx  (req_grid_idx),
    .req_feat_pack (req_feat_pack),
    .clean_req     (clean_req),
    .clean_done    (clean_done),
    .lin_start     (lin_start),
    .lin_grid_idx  (lin_grid_idx),
    .lin_feat_pack (lin_feat_pack),
    .lin_clean     (lin_clean),
    .lin_done      (lin_done),
    .busy          (busy),
    .issue_cnt     (issue_cnt),
    .coalesce_cnt  (coalesce_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic feat_t alt_feat();
    feat_t f;
    for (int i = 0; i < int'(L4_OUT_C); i++) f[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
    return f;
  endfunction

  function automatic feat_t fill_feat(input logic [7:0] v);
    feat_t f;
    for (int i = 0; i < int'(L4_OUT_C); i++) f[i] = v;
    return f;
  endfunction

  task automatic drive_req(input int unsigned g, input feat_t f);
    req_valid     = 1'b1;
    req_grid_idx  = grid_idx_t'(g);
    req_feat_pack = f;
  endtask

  task automatic pulse_done();
    lin_done = 1'b1;
    step();
    lin_done = 1'b0;
  endtask

  initial begin
    // reset values
    step();
    step();
    chk("rst_lin_start", lin_start, 0);
    chk("rst_lin_clean", lin_clean, 0);
    chk("rst_clean_done", clean_done, 0);
    chk("rst_lin_grid", lin_grid_idx, 0);
    chk("rst_lin_feat", lin_feat_pack, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_issue_cnt", issue_cnt, 0);
    chk("rst_coalesce_cnt", coalesce_cnt, 0);
    rst = 1'b0;
    step();

    // single request: lin_start at t+2 with operands held until lin_done
    drive_req(55, alt_feat());
    step();
    req_valid = 1'b0;
    chk("t1_start_t1", lin_start, 0);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_start_t2", lin_start, 1);
    chk("t1_grid", lin_grid_idx, 55);
    chk("t1_feat", lin_feat_pack, alt_feat());
    chk("t1_issue_cnt", issue_cnt, 1);
    step();
    chk("t1_start_pulse", lin_start, 0);
    step();
    chk("t1_grid_hold", lin_grid_idx, 55);
    chk("t1_feat_hold", lin_feat_pack, alt_feat());
    pulse_done();
    chk("t1_no_reissue", lin_start, 0);
    chk("t1_idle", busy, 0);

    // four queued requests while linear is busy
    drive_req(100, fill_feat(8'h10));
    step();
    req_valid = 1'b0;
    step();
    chk("t2_start_100", lin_start, 1);
    for (int k = 1; k <= 4; k++) begin
      drive_req(k, fill_feat(8'(k)));
      step();
    end
    req_valid = 1'b0;
    chk("t2_ready_full", req_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      pulse_done();
      chk("t2_start_after_done", lin_start, 1);
      chk("t2_order_grid", lin_grid_idx, 256'(k));
      chk("t2_order_feat", lin_feat_pack, fill_feat(8'(k)));
      step();
      chk("t2_start_single", lin_start, 0);
    end
    pulse_done();
    chk("t2_idle", busy, 0);
    chk("t2_issue_cnt", issue_cnt, 6);

    // coalescing two requests to grid 7
    drive_req(200, fill_feat(8'h20));
    step();
    req_valid = 1'b0;
    step();
    drive_req(7, fill_feat(8'h01));
    step();
    drive_req(7, fill_feat(8'h02));
    step();
    req_valid = 1'b0;
    chk("t3_coalesce_cnt", coalesce_cnt, 1);
    pulse_done();
    chk("t3_start", lin_start, 1);
    chk("t3_grid", lin_grid_idx, 7);
    chk("t3_feat", lin_feat_pack, fill_feat(8'h02));
    step();
    pulse_done();
    chk("t3_single_issue", lin_start, 0);
    chk("t3_idle", busy, 0);
    chk("t3_issue_cnt", issue_cnt, 8);

    // clean during RUN with two queued entries
    drive_req(300, fill_feat(8'h30));
    step();
    req_valid = 1'b0;
    step();
    drive_req(11, fill_feat(8'h11));
    step();
    drive_req(12, fill_feat(8'h12));
    step();
    req_valid = 1'b0;
    clean_req = 1'b1;
    step();
    clean_req = 1'b0;
    chk("t4_ready_pending", req_ready, 0);
    chk("t4_no_clean_yet", lin_clean, 0);
    chk("t4_busy", busy, 1);
    step();
    step();
    chk("t4_drain_no_clean", lin_clean, 0);
    pulse_done();
    chk("t4_lin_clean", lin_clean, 1);
    chk("t4_no_start", lin_start, 0);
    step();
    chk("t4_clean_done", clean_done, 1);
    chk("t4_lin_clean_pulse", lin_clean, 0);
    step();
    chk("t4_done_pulse", clean_done, 0);
    chk("t4_ready_back", req_ready, 1);
    chk("t4_idle", busy, 0);
    chk("t4_issue_cnt", issue_cnt, 9);

    // clean and request in the same cycle from IDLE
    drive_req(400, fill_feat(8'h40));
    clean_req = 1'b1;
    chk("t5_ready_at_c", req_ready, 1);
    step();
    req_valid = 1'b0;
    clean_req = 1'b0;
    chk("t5_lin_clean_c1", lin_clean, 1);
    step();
    chk("t5_clean_done_c2", clean_done, 1);
    chk("t5_no_start_c2", lin_start, 0);
    step();
    chk("t5_ready_c3", req_ready, 1);
    chk("t5_discarded", busy, 0);
    step();
    chk("t5_no_start_c4", lin_start, 0);
    chk("t5_issue_cnt", issue_cnt, 9);

    // asynchronous reset in RUN with a queued entry
    drive_req(500, fill_feat(8'h50));
    step();
    drive_req(501, fill_feat(8'h51));
    step();
    req_valid = 1'b0;
    chk("t6_start_before_rst", lin_start, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_start", lin_start, 0);
    chk("t6_rst_grid", lin_grid_idx, 0);
    chk("t6_rst_feat", lin_feat_pack, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", req_ready, 1);
    chk("t6_rst_issue_cnt", issue_cnt, 0);
    chk("t6_rst_coalesce_cnt", coalesce_cnt, 0);
    step();
    rst = 1'b0;
    step();
    drive_req(600, fill_feat(8'h60));
    step();
    req_valid = 1'b0;
    chk("t6_start_t1", lin_start, 0);
    step();
    chk("t6_start_t2", lin_start, 1);
    chk("t6_grid", lin_grid_idx, 600);
    chk("t6_issue_cnt", issue_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_scheduler.md
# fc_scheduler

Request scheduler and sequencer for the `linear` FC-head datapath. It accepts pooled-feature update requests (`grid_idx` plus the L4 feature vector) from the max-pool stage and buffers them in a small coalescing queue. It issues them one at a time to `linear` with a `module_start` pulse and holds operands stable until `module_done`. It also orders event-stream clean requests so that `event_stream_clean` reaches `linear` only when the FC unit is idle and all pending work has been flushed.

## Interface
- `L4_OUT_C`, 32, feature channels per request.
- `QUEUE_DEPTH`, 4, pending-request slots; power of two, ≥2.
- `CNT_W`, 16, width of status counters.
- `clk` in 1: the block's single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on `req_valid && req_ready`.
- `req_grid_idx` in `grid_idx_t`: grid cell of the request.
- `req_feat_pack` in `[L4_OUT_C-1:0][F_WIDTH-1:0]`: pooled features.
- `clean_req` in 1: single-cycle pulse requesting an event-stream clean.
- `clean_done` out 1: single-cycle pulse when the clean has completed.
- `lin_start` out 1: drives `linear.module_start`; single-cycle pulse.
- `lin_grid_idx` out `grid_idx_t`: drives `linear.grid_idx`.
- `lin_feat_pack` out `[L4_OUT_C-1:0][F_WIDTH-1:0]`: drives `linear.max_pool_dx_out_pack`.
- `lin_clean` out 1: drives `linear.event_stream_clean`; single-cycle pulse.
- `lin_done` in 1: from `linear.module_done`.
- `busy` out 1: the queue is non-empty, or the FSM is not in IDLE.
- `issue_cnt` out `CNT_W`: number of requests issued; saturating.
- `coalesce_cnt` out `CNT_W`: number of requests merged into an existing queue entry; saturating.

## Operation
- FSM states: IDLE, RUN, CLEAN_DRAIN, CLEAN_PULSE, CLEAN_ACK.
- Queue: circular FIFO of {grid_idx, feat_pack}, with registered valid bits. The in-flight entry is popped at issue.
- Accept path: `req_ready = !full && !clean_pending`.
  - On accept, if a queued entry has the same `grid_idx`, overwrite its `feat_pack` in place. That entry keeps its queue position and `coalesce_cnt` increments.
  - Otherwise push a new entry. At most one entry can match, because entries are unique by construction.
- IDLE with a non-empty queue: pop the head, load `lin_grid_idx`/`lin_feat_pack`, pulse `lin_start`, go to RUN.
- RUN: hold operands. On `lin_done`:
  - If the queue is non-empty and no clean is pending, issue the next entry immediately (stay in RUN).
  - If a clean is pending, go to CLEAN_PULSE.
  - Otherwise go to IDLE.
- `issue_cnt` increments on every `lin_start`.
- Clean handling:
  - `clean_req` sets `clean_pending` and flushes all queued (not in-flight) entries on the same edge.
  - From IDLE, go to CLEAN_PULSE. From RUN, go to CLEAN_DRAIN and wait for `lin_done` there, then go to CLEAN_PULSE.
  - CLEAN_PULSE asserts `lin_clean` for one cycle, then goes to CLEAN_ACK.
  - CLEAN_ACK asserts `clean_done` for one cycle, clears `clean_pending`, and returns to IDLE.
- `clean_req` while `clean_pending` is already set is ignored.
- `lin_done` in IDLE, CLEAN_PULSE or CLEAN_ACK is ignored.

## Timing
- Reset values:
  - Outputs: `lin_start=0`, `lin_clean=0`, `clean_done=0`, `lin_grid_idx=0`, `lin_feat_pack=0`, `req_ready=1`, `busy=0`, counters=0.
  - Internal: FSM in IDLE, queue empty.
- All outputs are registered except `req_ready`, which is combinational from registered state only.
- Issue latency from IDLE with an empty queue: request accepted in cycle t, `lin_start` high in cycle t+2.
- Back-to-back issue: `lin_done` high in cycle d, next `lin_start` high in cycle d+1.
- Operands are valid in the same cycle as `lin_start` and stay stable until the cycle after `lin_done`.
- Clean latency from IDLE: `clean_req` in cycle c, `lin_clean` in c+1, `clean_done` in c+2, `req_ready` high again in c+3.
- Clean latency from RUN: `lin_done` in cycle d, `lin_clean` in d+1, `clean_done` in d+2.
- Simultaneous events:
  - A request accepted in the same cycle as `clean_req` is discarded; clean wins.
  - `clean_req` together with `lin_done` gives no new issue; next state is CLEAN_PULSE.
  - Accept and pop in the same cycle with the queue full: the accept is blocked, because `req_ready` is computed from the registered full flag.
  - Coalesce onto the head entry in the same cycle it is popped: the new features are issued (write-before-pop forwarding).
- Reset mid-operation: all state is cleared asynchronously and no pulse output glitches high. The team's reset must also reset `linear`.

## Structure
- `grid_idx_t`, `F_WIDTH`, and an `fc_sched_state_e` enum belong in the `aegnn` package.
- Natural sub-module: `fc_req_queue`, the coalescing FIFO. Its ports are push, push data, match flag, pop, flush, head data, empty and full.
- `fc_scheduler` holds the FSM, counters and output registers.

## Test plan
- Single request `grid_idx=55`, features alternating 255/0 → `lin_start` at t+2 carrying the same operands; operands held until `lin_done`; `issue_cnt=1`.
- 4 requests with `grid_idx` 1,2,3,4 while `linear` is busy → `req_ready` low after the 4th; issued in order 1,2,3,4, each `lin_start` exactly 1 cycle after the previous `lin_done`.
- Requests `grid_idx=7` (features all 1) then `grid_idx=7` (features all 2), both queued → one issue carrying all-2 features; `coalesce_cnt=1`.
- `clean_req` during RUN with 2 entries queued → queue flushed; `lin_clean` 1 cycle after `lin_done`; `clean_done` the next cycle; `issue_cnt` unchanged by the flushed entries.
- `clean_req` and `req_valid` in the same cycle from IDLE → request discarded; `lin_clean` at c+1, `clean_done` at c+2; no `lin_start`.
- `rst` asserted in RUN with a non-empty queue → all outputs return to reset values immediately; a request after release is issued at t+2.
